// File: rtl/softmax_ctrl.sv
// Softmax sequencer: buffers a vector, tracks its maximum, then drives an external
// exp unit, accumulator and divider through req/ack handshakes, streaming results in order.
module softmax_ctrl #(
    parameter int DATA_SIZE = 32,
    parameter int NUM_DATA  = 10
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic                 exp_req_o,
    output logic [DATA_SIZE-1:0] exp_x_o,
    output logic [DATA_SIZE-1:0] exp_max_o,
    input  logic                 exp_ack_i,
    input  logic [DATA_SIZE-1:0] exp_res_i,
    output logic                 sum_clr_o,
    output logic                 sum_en_o,
    output logic [DATA_SIZE-1:0] sum_data_o,
    output logic                 div_req_o,
    output logic [DATA_SIZE-1:0] div_num_o,
    input  logic                 div_ack_i,
    input  logic [DATA_SIZE-1:0] div_res_i,
    output logic                 out_valid_o,
    output logic [DATA_SIZE-1:0] out_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [2:0]           state_o
);

    localparam int IW = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DATA - 1);
    localparam logic [DATA_SIZE-1:0] MSB = {1'b1, {(DATA_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EXP  = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Handshakes: a req stays high with stable data until ack is sampled high on a
    // rising edge; acks seen while the matching req is low are ignored.

    // Order-preserving key: unsigned compare of keys matches float ordering, +0 above -0.
    function automatic logic [DATA_SIZE-1:0] to_key(input logic [DATA_SIZE-1:0] w);
        return w[DATA_SIZE-1] ? ~w : (w | MSB);
    endfunction

    function automatic logic [DATA_SIZE-1:0] from_key(input logic [DATA_SIZE-1:0] k);
        return k[DATA_SIZE-1] ? (k & ~MSB) : ~k;
    endfunction

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_SIZE-1:0] max_key_q, max_key_d;
    logic                 exp_req_q, exp_req_d;
    logic [DATA_SIZE-1:0] exp_x_q, exp_x_d;
    logic [DATA_SIZE-1:0] exp_max_q, exp_max_d;
    logic                 sum_clr_q, sum_clr_d;
    logic                 sum_en_q, sum_en_d;
    logic [DATA_SIZE-1:0] sum_data_q, sum_data_d;
    logic                 div_req_q, div_req_d;
    logic [DATA_SIZE-1:0] div_num_q, div_num_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [DATA_SIZE-1:0] buf_q [NUM_DATA];
    logic                 buf_we;
    logic [IW-1:0]        buf_wa;
    logic [DATA_SIZE-1:0] buf_wd;
    logic [DATA_SIZE-1:0] data_key;
    logic [IW-1:0]        nxt_idx;

    assign nxt_idx = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        max_key_d   = max_key_q;
        exp_req_d   = exp_req_q;
        exp_x_d     = exp_x_q;
        exp_max_d   = exp_max_q;
        sum_clr_d   = 1'b0;
        sum_en_d    = 1'b0;
        sum_data_d  = sum_data_q;
        div_req_d   = div_req_q;
        div_num_d   = div_num_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        buf_we      = 1'b0;
        buf_wa      = idx_q;
        buf_wd      = data_i;
        data_key    = to_key(data_i);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    buf_we    = 1'b1;
                    buf_wa    = '0;
                    idx_d     = IW'(1);
                    max_key_d = data_key;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (start_i) begin
                    buf_we = 1'b1;
                    if (data_key > max_key_q) max_key_d = data_key;
                    if (idx_q == LAST) begin
                        // Last word folds into the max in time for the first request.
                        idx_d     = '0;
                        state_d   = S_EXP;
                        exp_req_d = 1'b1;
                        exp_x_d   = buf_q[0];
                        exp_max_d = from_key(max_key_d);
                        sum_clr_d = 1'b1;
                    end else begin
                        idx_d = nxt_idx;
                    end
                end else begin
                    err_d   = 1'b1;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_EXP: begin
                if (exp_req_q && exp_ack_i) begin
                    buf_we     = 1'b1;
                    buf_wd     = exp_res_i;
                    sum_en_d   = 1'b1;
                    sum_data_d = exp_res_i;
                    if (idx_q == LAST) begin
                        idx_d     = '0;
                        exp_req_d = 1'b0;
                        state_d   = S_DIV;
                    end else begin
                        idx_d   = nxt_idx;
                        exp_x_d = buf_q[nxt_idx];
                    end
                end
            end
            S_DIV: begin
                // First divide issues a cycle after entry so the final sum_en has landed.
                if (!div_req_q) begin
                    div_req_d = 1'b1;
                    div_num_d = buf_q[idx_q];
                end else if (div_ack_i) begin
                    out_valid_d = 1'b1;
                    out_data_d  = div_res_i;
                    if (idx_q == LAST) begin
                        idx_d     = '0;
                        div_req_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        idx_d     = nxt_idx;
                        div_num_d = buf_q[nxt_idx];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            max_key_q   <= '0;
            exp_req_q   <= 1'b0;
            exp_x_q     <= '0;
            exp_max_q   <= '0;
            sum_clr_q   <= 1'b0;
            sum_en_q    <= 1'b0;
            sum_data_q  <= '0;
            div_req_q   <= 1'b0;
            div_num_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            max_key_q   <= max_key_d;
            exp_req_q   <= exp_req_d;
            exp_x_q     <= exp_x_d;
            exp_max_q   <= exp_max_d;
            sum_clr_q   <= sum_clr_d;
            sum_en_q    <= sum_en_d;
            sum_data_q  <= sum_data_d;
            div_req_q   <= div_req_d;
            div_num_q   <= div_num_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (buf_we) buf_q[buf_wa] <= buf_wd;
    end

    assign exp_req_o   = exp_req_q;
    assign exp_x_o     = exp_x_q;
    assign exp_max_o   = exp_max_q;
    assign sum_clr_o   = sum_clr_q;
    assign sum_en_o    = sum_en_q;
    assign sum_data_o  = sum_data_q;
    assign div_req_o   = div_req_q;
    assign div_num_o   = div_num_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_softmax_ctrl.sv
// Bench for softmax_ctrl: table of 10-word vectors with expected max, bench-side exp/div
// responders, and queue scoreboards for exp requests, accumulator feed and outputs.
module tb_softmax_ctrl;

    localparam int W = 32;
    localparam int N = 10;

    typedef struct packed {
        logic [0:N-1][W-1:0] w;
        logic [W-1:0]        max;
        logic                rnd;
        logic                poke;
    } vec_t;

    logic         clk;
    logic         reset_n_i;
    logic         start_i;
    logic [W-1:0] data_i;
    logic         exp_req_o;
    logic [W-1:0] exp_x_o;
    logic [W-1:0] exp_max_o;
    logic         exp_ack_i;
    logic [W-1:0] exp_res_i;
    logic         sum_clr_o;
    logic         sum_en_o;
    logic [W-1:0] sum_data_o;
    logic         div_req_o;
    logic [W-1:0] div_num_o;
    logic         div_ack_i;
    logic [W-1:0] div_res_i;
    logic         out_valid_o;
    logic [W-1:0] out_data_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic [2:0]   state_o;

    softmax_ctrl #(.DATA_SIZE(W), .NUM_DATA(N)) dut (
        .clock_i    (clk),
        .reset_n_i  (reset_n_i),
        .start_i    (start_i),
        .data_i     (data_i),
        .exp_req_o  (exp_req_o),
        .exp_x_o    (exp_x_o),
        .exp_max_o  (exp_max_o),
        .exp_ack_i  (exp_ack_i),
        .exp_res_i  (exp_res_i),
        .sum_clr_o  (sum_clr_o),
        .sum_en_o   (sum_en_o),
        .sum_data_o (sum_data_o),
        .div_req_o  (div_req_o),
        .div_num_o  (div_num_o),
        .div_ack_i  (div_ack_i),
        .div_res_i  (div_res_i),
        .out_valid_o(out_valid_o),
        .out_data_o (out_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .state_o    (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sum_q[$];
    logic [W-1:0] div_q[$];
    logic [W-1:0] out_q[$];
    logic [W-1:0] cur_max;
    int n_vec, n_err;
    int hs_exp, req_cycles, clr_cnt, sen_cnt, out_cnt, done_cnt, err_cnt;
    bit exp_rand, stray;
    vec_t vecs [6];

    function automatic logic [W-1:0] f_exp(input logic [W-1:0] x);
        return {x[15:0], x[31:16]} ^ 32'h3C3C_0000;
    endfunction

    function automatic logic [W-1:0] f_div(input logic [W-1:0] n);
        return n + 32'h0001_1111;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, wanted %b", name, act, exp);
        end
    endtask

    task automatic fail_empty(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got an output, wanted none pending", name);
    endtask

    task automatic clear_counts();
        hs_exp = 0; req_cycles = 0; clr_cnt = 0; sen_cnt = 0;
        out_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, W'({exp_req_o, sum_clr_o, sum_en_o, div_req_o, out_valid_o,
                                 busy_o, done_o, err_o, state_o}), '0);
        check({tag, "_exp_x"}, exp_x_o, '0);
        check({tag, "_exp_max"}, exp_max_o, '0);
        check({tag, "_sum_data"}, sum_data_o, '0);
        check({tag, "_div_num"}, div_num_o, '0);
        check({tag, "_out_data"}, out_data_o, '0);
    endtask

    // ---------------- responders (exp unit, divider) ----------------
    initial begin : exp_resp
        int dly;
        dly = -1;
        exp_ack_i = 1'b0;
        exp_res_i = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n_i || exp_ack_i) begin
                exp_ack_i = 1'b0;
                dly = -1;
            end
            if (reset_n_i && exp_req_o) begin
                if (dly < 0) dly = exp_rand ? int'($urandom_range(0, 5)) : 0;
                if (dly == 0) begin
                    exp_ack_i = 1'b1;
                    exp_res_i = f_exp(exp_x_o);
                end else begin
                    dly--;
                end
            end else if (reset_n_i && stray) begin
                exp_ack_i = 1'($urandom_range(0, 1));
                exp_res_i = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin : div_resp
        int dly;
        dly = -1;
        div_ack_i = 1'b0;
        div_res_i = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n_i || div_ack_i) begin
                div_ack_i = 1'b0;
                dly = -1;
            end
            if (reset_n_i && div_req_o) begin
                if (dly < 0) dly = exp_rand ? int'($urandom_range(0, 5)) : 0;
                if (dly == 0) begin
                    div_ack_i = 1'b1;
                    div_res_i = f_div(div_num_o);
                end else begin
                    dly--;
                end
            end else if (reset_n_i && stray) begin
                div_ack_i = 1'($urandom_range(0, 1));
                div_res_i = 32'hBAD0_0BAD;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic prev_req, prev_ack;
        logic [W-1:0] prev_x;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_x   = '0;
        forever begin
            @(negedge clk);
            if (!reset_n_i) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (prev_req && !prev_ack) begin
                    check_bit("exp_req_hold", exp_req_o, 1'b1);
                    check("exp_x_stable", exp_x_o, prev_x);
                end
                if (exp_req_o) req_cycles++;
                if (exp_req_o && exp_ack_i) begin
                    hs_exp++;
                    if (exp_q.size() == 0) fail_empty("exp_x");
                    else check("exp_x", exp_x_o, exp_q.pop_front());
                    check("exp_max", exp_max_o, cur_max);
                end
                if (sum_clr_o) begin
                    clr_cnt++;
                    check_bit("clr_with_req", exp_req_o, 1'b1);
                end
                if (sum_en_o) begin
                    sen_cnt++;
                    if (sum_q.size() == 0) fail_empty("sum_data");
                    else check("sum_data", sum_data_o, sum_q.pop_front());
                end
                if (div_req_o && div_ack_i) begin
                    if (div_q.size() == 0) fail_empty("div_num");
                    else check("div_num", div_num_o, div_q.pop_front());
                end
                if (out_valid_o) begin
                    out_cnt++;
                    if (out_q.size() == 0) fail_empty("out_data");
                    else check("out_data", out_data_o, out_q.pop_front());
                end
                if (done_o) done_cnt++;
                if (err_o) err_cnt++;
                prev_req = exp_req_o;
                prev_ack = exp_ack_i;
                prev_x   = exp_x_o;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_expect(input vec_t v);
        cur_max = v.max;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(v.w[i]);
            sum_q.push_back(f_exp(v.w[i]));
            div_q.push_back(f_exp(v.w[i]));
            out_q.push_back(f_div(f_exp(v.w[i])));
        end
    endtask

    task automatic stream_words(input vec_t v, input int count);
        for (int i = 0; i < count; i++) begin
            @(posedge clk); #1;
            start_i = 1'b1;
            data_i  = v.w[i];
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        data_i  = '0;
    endtask

    task automatic run_vec(input vec_t v);
        clear_counts();
        exp_rand = v.rnd;
        stray    = v.rnd;
        load_expect(v);
        stream_words(v, N);
        check_bit("lat_exp_req", exp_req_o, 1'b1);
        check_bit("lat_sum_clr", sum_clr_o, 1'b1);
        if (v.poke) begin
            for (int c = 0; c < 500 && !div_req_o; c++) begin
                @(posedge clk); #1;
            end
            check_bit("div_reached", div_req_o, 1'b1);
            @(posedge clk); #1;
            start_i = 1'b1;
            data_i  = 32'h7F00_0000;
            @(posedge clk); #1;
            data_i  = 32'h0000_0001;
            @(posedge clk); #1;
            start_i = 1'b0;
            data_i  = '0;
        end
        for (int c = 0; c < 3000 && done_cnt == 0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("n_exp_hs", W'(hs_exp), W'(N));
        check("n_sum_clr", W'(clr_cnt), 32'd1);
        check("n_sum_en", W'(sen_cnt), W'(N));
        check("n_out", W'(out_cnt), W'(N));
        check("n_done", W'(done_cnt), 32'd1);
        check("n_err", W'(err_cnt), 32'd0);
        check_bit("idle_busy", busy_o, 1'b0);
        check("left_exp", W'(exp_q.size() + sum_q.size()), 32'd0);
        check("left_out", W'(div_q.size() + out_q.size()), 32'd0);
        stray = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_vec = 0; n_err = 0;
        exp_rand = 1'b0; stray = 1'b0;
        cur_max = '0;
        clear_counts();
        start_i = 1'b0;
        data_i  = '0;
        reset_n_i = 1'b0;

        vecs[0].w = '{32'h40AB0A3D, 32'h418A49BA, 32'h4158C8B4, 32'h41A0ED91, 32'h40B5FBE7,
                      32'h40FE872B, 32'h41035810, 32'h4166B020, 32'h4184126E, 32'h3E1CAC08};
        vecs[0].max = 32'h41A0ED91; vecs[0].rnd = 1'b0; vecs[0].poke = 1'b0;
        vecs[1].w = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC1200000, 32'hBFC00000,
                      32'hC0A00000, 32'hC2C80000, 32'hC0800000, 32'hC1000000, 32'hC0E00000};
        vecs[1].max = 32'hBF800000; vecs[1].rnd = 1'b0; vecs[1].poke = 1'b0;
        vecs[2].w = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000, 32'h80000001,
                      32'hBE000000, 32'hC2000000, 32'h80000000, 32'hC1000000, 32'hBF000000};
        vecs[2].max = 32'h00000000; vecs[2].rnd = 1'b0; vecs[2].poke = 1'b0;
        vecs[3].w = '{32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3E800000, 32'hBF800000,
                      32'h40400000, 32'h00000000, 32'h40800000, 32'h80000000, 32'h42C80000};
        vecs[3].max = 32'h42C80000; vecs[3].rnd = 1'b1; vecs[3].poke = 1'b0;
        vecs[4].w = '{32'h7F7FFFFF, 32'h7F000000, 32'hFF7FFFFF, 32'h3F800000, 32'h7F7FFFFE,
                      32'h00000001, 32'hC0000000, 32'h7E000000, 32'h80000001, 32'h40000000};
        vecs[4].max = 32'h7F7FFFFF; vecs[4].rnd = 1'b1; vecs[4].poke = 1'b0;
        vecs[5].w = '{32'hC2480000, 32'h00000001, 32'h80000001, 32'h3A83126F, 32'hC47A0000,
                      32'h00800000, 32'hBA83126F, 32'h00000002, 32'h807FFFFF, 32'h00000000};
        vecs[5].max = 32'h3A83126F; vecs[5].rnd = 1'b1; vecs[5].poke = 1'b1;

        #3;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 reset_n_i = 1'b1;
        repeat (2) @(posedge clk);

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // Short load: start drops after four words.
        clear_counts();
        stream_words(vecs[0], 4);
        check_bit("short_busy", busy_o, 1'b1);
        @(posedge clk); #1;
        check_bit("short_err", err_o, 1'b1);
        check_bit("short_idle", busy_o, 1'b0);
        @(posedge clk); #1;
        check_bit("short_err_pulse", err_o, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("short_no_req", W'(req_cycles), 32'd0);
        check("short_err_cnt", W'(err_cnt), 32'd1);

        // Reset in the middle of the exp phase, then a clean run.
        clear_counts();
        exp_rand = 1'b0;
        load_expect(vecs[0]);
        stream_words(vecs[0], N);
        for (int c = 0; c < 200 && hs_exp < 3; c++) @(posedge clk);
        check("mid_hs", W'(hs_exp), 32'd3);
        #2 reset_n_i = 1'b0;
        #1 check_reset_outputs("mid_rst");
        exp_q.delete(); sum_q.delete(); div_q.delete(); out_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n_i = 1'b1;
        check("mid_done", W'(done_cnt), 32'd0);
        check("mid_err", W'(err_cnt), 32'd0);
        repeat (2) @(posedge clk);
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
